// File: rtl/bmp_pix_unpack.sv
// bmp_pix_unpack: turns the SD-card BMP byte stream into RGB565 pixel writes.
// Skips the file header, unpacks packed B,G,R bytes from 16-bit words
// (first byte in [15:8]), drops the per-row padding to a 4-byte boundary and
// strobes one RGB565 pixel per R byte.
// Optional feature macro: BMP_PIX_UNPACK_COLOR_KEY_EN (transparency key remap).
module bmp_pix_unpack #(
    parameter int HDR_BYTES = 54,
    parameter int IMG_W     = 1024,
    parameter int IMG_H     = 768
`ifdef BMP_PIX_UNPACK_COLOR_KEY_EN
    ,
    parameter logic [23:0] KEY_RGB = 24'hFF00FF,
    parameter logic [15:0] KEY_OUT = 16'h0001
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pic_start,
    input  logic        sd_rd_val_en,
    input  logic [15:0] sd_rd_val_data,
    output logic        pix_en,
    output logic [15:0] pix_data,
    output logic        pic_done,
    output logic        busy
);

    localparam int ROW_PAD = (4 - ((IMG_W * 3) % 4)) % 4;
    localparam int PIX_NUM = IMG_W * IMG_H;
    localparam int PW      = $clog2(PIX_NUM + 1);
    localparam int CW      = $clog2(IMG_W + 1);
    localparam int HW      = (HDR_BYTES > 2) ? $clog2(HDR_BYTES) : 1;

    localparam logic [HW-1:0] HDR_LAST = HW'(HDR_BYTES - 1);
    localparam logic [CW-1:0] COL_END  = CW'(IMG_W);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_NUM - 1);
    localparam logic [1:0]    PAD_LAST = 2'((ROW_PAD == 0) ? 0 : ROW_PAD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PIX,
        DONE
    } state_t;

    state_t         state, state_n;
    logic [HW-1:0]  hdr_cnt, hdr_n;
    logic [1:0]     phase, phase_n;
    logic [CW-1:0]  col_cnt, col_n;
    logic [1:0]     pad_cnt, pad_n;
    logic [PW-1:0]  pix_cnt, pixc_n;
    logic [7:0]     b_hold, b_n;
    logic [7:0]     g_hold, g_n;
    logic [7:0]     lane_byte;
    logic [15:0]    rgb565;
    logic [15:0]    pix_n;
    logic           emit_n;
    logic           done_n;

    // State register for the picture parser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Walk both byte lanes of the word in order and classify each as header, colour or padding.
    always_comb begin
        state_n   = state;
        hdr_n     = hdr_cnt;
        phase_n   = phase;
        col_n     = col_cnt;
        pad_n     = pad_cnt;
        pixc_n    = pix_cnt;
        b_n       = b_hold;
        g_n       = g_hold;
        pix_n     = pix_data;
        lane_byte = 8'h00;
        rgb565    = 16'h0000;
        emit_n    = 1'b0;
        done_n    = 1'b0;

        if (pic_start) begin
            state_n = HDR;
            hdr_n   = '0;
            phase_n = 2'd0;
            col_n   = '0;
            pad_n   = 2'd0;
            pixc_n  = '0;
        end else if (sd_rd_val_en) begin
            for (int lane = 0; lane < 2; lane++) begin
                lane_byte = (lane == 0) ? sd_rd_val_data[15:8] : sd_rd_val_data[7:0];
                case (state_n)
                    HDR: begin
                        if (hdr_n == HDR_LAST) begin
                            hdr_n   = '0;
                            state_n = PIX;
                        end else begin
                            hdr_n = hdr_n + 1'b1;
                        end
                    end
                    PIX: begin
                        if ((ROW_PAD != 0) && (col_n == COL_END)) begin
                            if (pad_n == PAD_LAST) begin
                                pad_n = 2'd0;
                                col_n = '0;
                            end else begin
                                pad_n = pad_n + 2'd1;
                            end
                        end else begin
                            case (phase_n)
                                2'd0: begin
                                    b_n     = lane_byte;
                                    phase_n = 2'd1;
                                end
                                2'd1: begin
                                    g_n     = lane_byte;
                                    phase_n = 2'd2;
                                end
                                2'd2: begin
                                    rgb565 = {lane_byte[7:3], g_n[7:2], b_n[7:3]};
`ifdef BMP_PIX_UNPACK_COLOR_KEY_EN
                                    if ({lane_byte, g_n, b_n} == KEY_RGB) begin
                                        pix_n = KEY_OUT;
                                    end else if (rgb565 == KEY_OUT) begin
                                        pix_n = KEY_OUT ^ 16'h0020;
                                    end else begin
                                        pix_n = rgb565;
                                    end
`else
                                    pix_n = rgb565;
`endif
                                    emit_n  = 1'b1;
                                    phase_n = 2'd0;
                                    col_n   = col_n + 1'b1;
                                    if ((ROW_PAD == 0) && (col_n == COL_END)) begin
                                        col_n = '0;
                                    end
                                    if (pixc_n == PIX_LAST) begin
                                        state_n = DONE;
                                        done_n  = 1'b1;
                                    end
                                    pixc_n = pixc_n + 1'b1;
                                end
                                default: phase_n = 2'd0;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Counters, colour holding bytes and the registered pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt  <= '0;
            phase    <= 2'd0;
            col_cnt  <= '0;
            pad_cnt  <= 2'd0;
            pix_cnt  <= '0;
            b_hold   <= 8'h00;
            g_hold   <= 8'h00;
            pix_en   <= 1'b0;
            pix_data <= 16'h0000;
            pic_done <= 1'b0;
            busy     <= 1'b0;
        end else begin
            hdr_cnt  <= hdr_n;
            phase    <= phase_n;
            col_cnt  <= col_n;
            pad_cnt  <= pad_n;
            pix_cnt  <= pixc_n;
            b_hold   <= b_n;
            g_hold   <= g_n;
            pix_en   <= emit_n;
            pix_data <= pix_n;
            pic_done <= done_n;
            busy     <= (state_n == HDR) || (state_n == PIX);
        end
    end

endmodule

// File: tb/tb_bmp_pix_unpack.sv
// tb_bmp_pix_unpack: randomized scoreboard bench for bmp_pix_unpack.
// A picture is built as a plain byte array (header, B/G/R triples, 0xEE row
// padding); the driver pushes the expected RGB565 value of every R byte it
// sends, and a monitor pops and compares on each pix_en strobe.
module tb_bmp_pix_unpack;

    localparam int W      = 50;
    localparam int H      = 35;
    localparam int HB     = 54;
    localparam int PAD    = (4 - ((W * 3) % 4)) % 4;
    localparam int NPIX   = W * H;
    localparam int ROWB   = W * 3 + PAD;
    localparam int NBYTES = HB + H * ROWB;
    localparam int NWORDS = (NBYTES + 1) / 2;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pic_start = 1'b0;
    logic        sd_rd_val_en = 1'b0;
    logic [15:0] sd_rd_val_data = 16'h0000;
    logic        pix_en;
    logic [15:0] pix_data;
    logic        pic_done;
    logic        busy;

    logic [7:0]  stream [NBYTES + 1];
    int          rtag   [NBYTES + 1];
    logic [7:0]  pr [NPIX];
    logic [7:0]  pg [NPIX];
    logic [7:0]  pb [NPIX];

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_strobe = 0;
    int          n_done = 0;

    bmp_pix_unpack #(
        .HDR_BYTES(HB),
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pic_start(pic_start),
        .sd_rd_val_en(sd_rd_val_en),
        .sd_rd_val_data(sd_rd_val_data),
        .pix_en(pix_en),
        .pix_data(pix_data),
        .pic_done(pic_done),
        .busy(busy)
    );

    always #10 clk = ~clk;

    // Cycle stamp used to check the one-cycle output latency.
    always @(posedge clk) cyc++;

    // Hard stop in case the design never drains.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] model565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int v;
        v = (int'(r) / 8) * 2048 + (int'(g) / 4) * 32 + int'(b) / 8;
`ifdef BMP_PIX_UNPACK_COLOR_KEY_EN
        if (r == 8'hFF && g == 8'h00 && b == 8'hFF) return 16'h0001;
        if (v == 1) return 16'h0021;
`endif
        return 16'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic buildPicture();
        for (int i = 0; i < NPIX; i++) begin
            pr[i] = 8'($urandom);
            pg[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        pr[50] = 8'hFF; pg[50] = 8'h00; pb[50] = 8'hFF;
        pr[51] = 8'h05; pg[51] = 8'h03; pb[51] = 8'h0C;
        for (int p = 0; p <= NBYTES; p++) begin
            stream[p] = 8'hEE;
            rtag[p]   = -1;
        end
        for (int p = 0; p < HB; p++) stream[p] = 8'($urandom);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int base;
                base = HB + r * ROWB + c * 3;
                stream[base]     = pb[r * W + c];
                stream[base + 1] = pg[r * W + c];
                stream[base + 2] = pr[r * W + c];
                rtag[base + 2]   = r * W + c;
            end
        end
    endtask

    task automatic applyStimulus(input int first_w, input int last_w, input int max_gap, input bit expect_out);
        for (int w = first_w; w <= last_w; w++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                sd_rd_val_en = 1'b0;
            end
            @(negedge clk);
            sd_rd_val_en   = 1'b1;
            sd_rd_val_data = {stream[2 * w], stream[2 * w + 1]};
            if (expect_out) begin
                for (int l = 0; l < 2; l++) begin
                    int idx;
                    idx = rtag[2 * w + l];
                    if (idx >= 0) begin
                        exp_t e;
                        e.data  = model565(pr[idx], pg[idx], pb[idx]);
                        e.last  = (idx == NPIX - 1);
                        e.stamp = cyc + 1;
                        sbq.push_back(e);
                    end
                end
            end
        end
        @(negedge clk);
        sd_rd_val_en = 1'b0;
    endtask

    task automatic startPicture(input bit with_word);
        @(negedge clk);
        pic_start      = 1'b1;
        sd_rd_val_en   = with_word;
        sd_rd_val_data = 16'hA5A5;
        @(negedge clk);
        pic_start    = 1'b0;
        sd_rd_val_en = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: every strobe must match the oldest expected pixel, its done flag and its cycle.
    always @(negedge clk) begin
        if (pix_en) begin
            n_strobe++;
            if (sbq.size() == 0) begin
                checkOutput("unexpected_pix", {16'h0, pix_data}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("pix_data", 32'(pix_data), 32'(e.data));
                checkOutput("pic_done", 32'(pic_done), 32'(e.last));
                checkOutput("latency", 32'(cyc), 32'(e.stamp));
                if (pic_done) checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end else if (pic_done) begin
            checkOutput("done_without_pix", 32'(pix_en), 32'd1);
        end
        if (pic_done) n_done++;
    end

    // Main sequence: reset, idle words, full pictures, abort, post-done words, mid-picture reset.
    initial begin
        int s0;
        int d0;
        int wmid;

        repeat (3) @(negedge clk);
        checkOutput("rst_pix_en", 32'(pix_en), 32'd0);
        checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
        checkOutput("rst_pic_done", 32'(pic_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        buildPicture();

        s0 = n_strobe;
        applyStimulus(0, 9, 0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("idle_words_strobes", 32'(n_strobe - s0), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        s0 = n_strobe; d0 = n_done;
        startPicture(1'b0);
        applyStimulus(0, NWORDS - 1, 0, 1'b1);
        waitDrain();
        checkOutput("strobes_back2back", 32'(n_strobe - s0), 32'(NPIX));
        checkOutput("done_back2back", 32'(n_done - d0), 32'd1);
        checkOutput("busy_after_pic", 32'(busy), 32'd0);

        s0 = n_strobe; d0 = n_done;
        startPicture(1'b0);
        applyStimulus(0, NWORDS - 1, 3, 1'b1);
        waitDrain();
        checkOutput("strobes_gapped", 32'(n_strobe - s0), 32'(NPIX));
        checkOutput("done_gapped", 32'(n_done - d0), 32'd1);

        s0 = n_strobe; d0 = n_done;
        startPicture(1'b0);
        wmid = (HB + (99 / W) * ROWB + (99 % W) * 3 + 2) / 2 + 2;
        applyStimulus(0, wmid, 0, 1'b1);
        waitDrain();
        checkOutput("strobes_before_abort", 32'(n_strobe - s0), 32'd100);
        startPicture(1'b1);
        applyStimulus(0, NWORDS - 1, 2, 1'b1);
        waitDrain();
        checkOutput("strobes_after_abort", 32'(n_strobe - s0), 32'(100 + NPIX));
        checkOutput("done_after_abort", 32'(n_done - d0), 32'd1);

        s0 = n_strobe;
        applyStimulus(0, 19, 0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("post_done_strobes", 32'(n_strobe - s0), 32'd0);
        checkOutput("post_done_busy", 32'(busy), 32'd0);

        startPicture(1'b0);
        applyStimulus(0, 300, 0, 1'b1);
        waitDrain();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pix_en", 32'(pix_en), 32'd0);
        checkOutput("midrst_pix_data", 32'(pix_data), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_strobe;
        applyStimulus(301, 400, 0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("after_rst_strobes", 32'(n_strobe - s0), 32'd0);
        checkOutput("after_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
